// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with fill count, almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered read.
module sync_fifo_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = $clog2(DEPTH),
  parameter int unsigned AF_LEVEL   = DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_W:0] DepthCnt = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AfCnt    = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AeCnt    = AE_LEVEL[ADDR_W:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_acc, wr_acc;

  // Flags decode the registered count directly, so they move with count.
  always_comb begin
    full         = (count_q == DepthCnt);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AfCnt);
    almost_empty = (count_q <= AeCnt);
    count        = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

  // A write while full is only accepted when a read frees a slot in the same cycle.
  always_comb begin
    rd_acc = r_en && !empty;
    wr_acc = w_en && (!full || rd_acc);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Set takes priority over a simultaneous clear.
  always_comb begin
    overflow_d  = (w_en && !wr_acc) || (overflow_q && !err_clr);
    underflow_d = (r_en && !rd_acc) || (underflow_q && !err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented combinationally; forced to zero while empty so reset reads 0.
  always_comb begin
    data_out = empty ? '0 : mem[rd_ptr_q];
  end
`else
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (rd_acc) begin
      data_q <= mem[rd_ptr_q];
    end
  end

  always_comb begin
    data_out = data_q;
  end
`endif

endmodule
